// File: rtl/dm_access_ctrl.sv
// ============================================================================
// dm_access_ctrl : load/store front end for a word-addressed data memory
//                  (sub-word read-modify-write, load alignment/extension)
// Revision 1.0
// ============================================================================
`default_nettype none

module dm_access_ctrl #(
  parameter int data_size = 32,
  parameter int addr_size = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [addr_size+1:0]   req_addr,
  input  logic [data_size-1:0]   req_wdata,
  output logic                   rsp_valid,
  output logic                   rsp_err,
  output logic [data_size-1:0]   rsp_data,
  output logic                   enable_mem,
  output logic                   enable_fetch,
  output logic                   enable_writeback,
  output logic [addr_size-1:0]   DM_out_address,
  output logic [addr_size-1:0]   DM_in_address,
  output logic [data_size-1:0]   DMin,
  input  logic [data_size-1:0]   DMout
);

  localparam logic [1:0] c_size_byte = 2'b00;
  localparam logic [1:0] c_size_half = 2'b01;
  localparam logic [1:0] c_size_word = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_LD   = 3'd2,
    S_WR   = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t                 r_state;
  logic                   r_write;
  logic [1:0]             r_size;
  logic                   r_unsigned;
  logic [addr_size-1:0]   r_word;
  logic [1:0]             r_off;
  logic [15:0]            r_wdata;
  logic [data_size-1:0]   r_dmin;

  logic                   w_misaligned;
  logic                   w_subword_wr;
  logic [7:0]             w_byte;
  logic [15:0]            w_half;
  logic [data_size-1:0]   w_merged;
  logic [data_size-1:0]   w_load_data;

  assign req_ready = reset && (r_state == S_IDLE);

  assign w_misaligned = (req_size == 2'b11) ||
                        ((req_size == c_size_half) && req_addr[0]) ||
                        ((req_size == c_size_word) && (req_addr[1:0] != 2'b00));

  // The merged word depends on DMout, which is only valid during the WR
  // cycle of a sub-word store, so DMin is muxed combinationally there.
  assign w_subword_wr = (r_state == S_WR) && (r_size != c_size_word);
  assign DMin         = w_subword_wr ? w_merged : r_dmin;

  assign w_byte = DMout[{r_off, 3'b000} +: 8];
  assign w_half = DMout[{r_off[1], 4'b0000} +: 16];

  always_comb begin
    w_merged = DMout;
    if (r_size == c_size_byte)
      w_merged[{r_off, 3'b000} +: 8] = r_wdata[7:0];
    else
      w_merged[{r_off[1], 4'b0000} +: 16] = r_wdata;
  end

  always_comb begin
    w_load_data = DMout;
    case (r_size)
      c_size_byte: w_load_data = {{(data_size-8){~r_unsigned & w_byte[7]}}, w_byte};
      c_size_half: w_load_data = {{(data_size-16){~r_unsigned & w_half[15]}}, w_half};
      default:     w_load_data = DMout;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= S_IDLE;
      r_write          <= 1'b0;
      r_size           <= 2'b00;
      r_unsigned       <= 1'b0;
      r_word           <= '0;
      r_off            <= 2'b00;
      r_wdata          <= '0;
      r_dmin           <= '0;
      rsp_valid        <= 1'b0;
      rsp_err          <= 1'b0;
      rsp_data         <= '0;
      enable_mem       <= 1'b0;
      enable_fetch     <= 1'b0;
      enable_writeback <= 1'b0;
      DM_out_address   <= '0;
      DM_in_address    <= '0;
    end else begin
      rsp_valid        <= 1'b0;
      rsp_err          <= 1'b0;
      enable_mem       <= 1'b0;
      enable_fetch     <= 1'b0;
      enable_writeback <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write    <= req_write;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_word     <= req_addr[addr_size+1:2];
            r_off      <= req_addr[1:0];
            r_wdata    <= req_wdata[15:0];
            if (w_misaligned) begin
              r_state <= S_ERR;
            end else if (req_write && (req_size == c_size_word)) begin
              r_state          <= S_WR;
              enable_mem       <= 1'b1;
              enable_writeback <= 1'b1;
              DM_in_address    <= req_addr[addr_size+1:2];
              r_dmin           <= req_wdata;
            end else begin
              r_state        <= S_RD;
              enable_mem     <= 1'b1;
              enable_fetch   <= 1'b1;
              DM_out_address <= req_addr[addr_size+1:2];
            end
          end
        end
        S_RD: begin
          if (r_write) begin
            r_state          <= S_WR;
            enable_mem       <= 1'b1;
            enable_writeback <= 1'b1;
            DM_in_address    <= r_word;
          end else begin
            r_state <= S_LD;
          end
        end
        S_LD: begin
          rsp_valid <= 1'b1;
          rsp_data  <= w_load_data;
          r_state   <= S_IDLE;
        end
        S_WR: begin
          rsp_valid <= 1'b1;
          rsp_data  <= '0;
          if (w_subword_wr)
            r_dmin <= w_merged;
          r_state   <= S_IDLE;
        end
        S_ERR: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_data  <= '0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dm_access_ctrl.sv
// ============================================================================
// tb_dm_access_ctrl : directed scoreboard bench with a behavioural memory
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_dm_access_ctrl;
  localparam int DW = 32;
  localparam int AW = 12;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_write = 1'b0;
  logic [1:0]     req_size = 2'b00;
  logic           req_unsigned = 1'b0;
  logic [AW+1:0]  req_addr = '0;
  logic [DW-1:0]  req_wdata = '0;
  logic           req_ready;
  logic           rsp_valid;
  logic           rsp_err;
  logic [DW-1:0]  rsp_data;
  logic           enable_mem;
  logic           enable_fetch;
  logic           enable_writeback;
  logic [AW-1:0]  DM_out_address;
  logic [AW-1:0]  DM_in_address;
  logic [DW-1:0]  DMin;
  logic [DW-1:0]  DMout = '0;

  logic [DW-1:0]  mem [0:(1<<AW)-1];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int en_cnt = 0;
  int en_base = 0;

  typedef struct {
    logic          err;
    logic [DW-1:0] data;
    int            acc;
    int            lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  dm_access_ctrl #(.data_size(DW), .addr_size(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_data(rsp_data), .enable_mem(enable_mem), .enable_fetch(enable_fetch),
    .enable_writeback(enable_writeback), .DM_out_address(DM_out_address),
    .DM_in_address(DM_in_address), .DMin(DMin), .DMout(DMout)
  );

  always #5 clk = ~clk;

  // Synchronous-read data memory: DMout is valid the cycle after a fetch edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (enable_mem && enable_fetch)     DMout <= mem[DM_out_address];
    if (enable_mem && enable_writeback) mem[DM_in_address] <= DMin;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (enable_mem) en_cnt++;
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_rsp observed=1 expected=0");
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
        chk("rsp_data", rsp_data, mon_e.data);
        chk("rsp_latency", DW'(cyc - mon_e.acc), DW'(mon_e.lat));
      end
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [AW+1:0] a, input logic [DW-1:0] d,
                       input logic e_err, input logic [DW-1:0] e_data,
                       input bit b2b, input bit expect_rsp);
    int   n = 0;
    exp_t e;
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $error("FAIL accept_timeout observed=0 expected=1");
      req_valid = 1'b0;
      return;
    end
    if (b2b) chk("b2b_accept_with_rsp", {31'b0, rsp_valid}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (expect_rsp) begin
      e.err  = e_err;
      e.data = e_data;
      e.acc  = cyc;
      e.lat  = (e_err || (w && sz == 2'b10)) ? 1 : 2;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $error("FAIL idle_timeout observed=%0d expected=0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_enable_mem", {31'b0, enable_mem}, 32'd0);
    chk("rst_dmin", DMin, 32'd0);
    chk("rst_in_addr", DW'(DM_in_address), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

    // Word store then word load
    issue(1'b1, 2'b10, 1'b0, 14'h010, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("ws_in_addr", DW'(DM_in_address), 32'd4);
    chk("ws_wb_strobe", {31'b0, enable_writeback}, 32'd1);
    chk("ws_dmin", DMin, 32'hDEADBEEF);
    wait_idle();
    issue(1'b0, 2'b10, 1'b0, 14'h010, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1);
    wait_idle();

    // Byte store merge (upper wdata bits must be ignored)
    issue(1'b1, 2'b00, 1'b0, 14'h012, 32'hFFFFFF55, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("bs_rd_fetch", {31'b0, enable_fetch}, 32'd1);
    chk("bs_rd_addr", DW'(DM_out_address), 32'd4);
    @(negedge clk);
    chk("bs_wr_strobe", {31'b0, enable_writeback}, 32'd1);
    chk("bs_dmin", DMin, 32'hDE55BEEF);
    wait_idle();
    issue(1'b0, 2'b10, 1'b0, 14'h010, 32'h0, 1'b0, 32'hDE55BEEF, 1'b0, 1'b1);
    wait_idle();

    // Load extension
    issue(1'b0, 2'b00, 1'b0, 14'h013, 32'h0, 1'b0, 32'hFFFFFFDE, 1'b0, 1'b1);
    wait_idle();
    issue(1'b0, 2'b01, 1'b1, 14'h010, 32'h0, 1'b0, 32'h0000BEEF, 1'b0, 1'b1);
    wait_idle();
    issue(1'b0, 2'b01, 1'b0, 14'h010, 32'h0, 1'b0, 32'hFFFFBEEF, 1'b0, 1'b1);
    wait_idle();
    issue(1'b0, 2'b00, 1'b1, 14'h012, 32'h0, 1'b0, 32'h00000055, 1'b0, 1'b1);
    wait_idle();

    // Misaligned and illegal requests never touch memory
    en_base = en_cnt;
    issue(1'b0, 2'b10, 1'b0, 14'h011, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
    chk("mis_no_enable", {31'b0, enable_mem}, 32'd0);
    wait_idle();
    issue(1'b1, 2'b01, 1'b0, 14'h013, 32'hCAFE, 1'b1, 32'h0, 1'b0, 1'b1);
    wait_idle();
    issue(1'b0, 2'b11, 1'b0, 14'h010, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
    wait_idle();
    chk("mis_enable_count", DW'(en_cnt - en_base), 32'd0);
    chk("mis_mem_kept", mem[4], 32'hDE55BEEF);

    // Back-to-back with req_valid held high
    issue(1'b1, 2'b10, 1'b0, 14'h040, 32'h11223344, 1'b0, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 2'b00, 1'b1, 14'h041, 32'h0, 1'b0, 32'h00000033, 1'b1, 1'b1);
    issue(1'b1, 2'b01, 1'b0, 14'h042, 32'h0000ABCD, 1'b0, 32'h0, 1'b1, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 14'h040, 32'h0, 1'b0, 32'hABCD3344, 1'b1, 1'b1);
    wait_idle();

    // Reset during the WR state of a word store
    issue(1'b1, 2'b10, 1'b0, 14'h020, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0, 1'b1);
    wait_idle();
    issue(1'b1, 2'b10, 1'b0, 14'h020, 32'h12345678, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("pre_rst_in_wr", {31'b0, enable_writeback}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_enable_mem", {31'b0, enable_mem}, 32'd0);
    chk("mid_rst_enable_wb", {31'b0, enable_writeback}, 32'd0);
    chk("mid_rst_in_addr", DW'(DM_in_address), 32'd0);
    chk("mid_rst_dmin", DMin, 32'd0);
    chk("mid_rst_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("mid_rst_word8", mem[8], 32'hA5A5A5A5);
    reset = 1'b1;
    #1;
    chk("rel_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    issue(1'b0, 2'b10, 1'b0, 14'h020, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b1);
    wait_idle();
    chk("sb_drained", DW'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
